// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_pkg
// Purpose  : Shared types and helpers for the multi-slot alarm controller.
//            Defines the packed BCD mm:ss time type, a BCD validity check,
//            and the controller state encoding.
// Revision : 1.0  initial release
// ============================================================================
package alarm_pkg;

  // Same packing as the counter_60 chain:
  // {min_tens[2:0], min_ones[3:0], sec_tens[2:0], sec_ones[3:0]}
  typedef struct packed {
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
  } time_bcd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_e;

  // Index width is fixed at 4 so the port map does not move with NUM_ALARMS.
  localparam int C_IDX_W = 4;

  function automatic logic bcd_valid(input time_bcd_t t);
    return (t.min_tens <= 3'd5) && (t.min_ones <= 4'd9) &&
           (t.sec_tens <= 3'd5) && (t.sec_ones <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_slot_bank.sv
`default_nettype none
// ============================================================================
// Module   : alarm_slot_bank
// Purpose  : Register file of NUM_ALARMS alarm slots (time + arm bit), write
//            validation, per-slot comparator against the current time, and a
//            lowest-index priority encoder.
// Ports    : clk, rst_n            clock / async active-low reset
//            wr_en/wr_idx/wr_time/wr_arm  slot write port
//            cur_time              running clock time
//            hit, hit_idx          combinational match result
//            armed_mask            per-slot arm bits
//            wr_err                one-cycle pulse on a rejected write
// Revision : 1.0  initial release
// ============================================================================
module alarm_slot_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [C_IDX_W-1:0]    wr_idx,
  input  time_bcd_t             wr_time,
  input  logic                  wr_arm,
  input  time_bcd_t             cur_time,
  output logic                  hit,
  output logic [C_IDX_W-1:0]    hit_idx,
  output logic [NUM_ALARMS-1:0] armed_mask,
  output logic                  wr_err
);

  logic                  w_idx_ok;
  logic                  w_accept;
  logic [NUM_ALARMS-1:0] w_match;
  logic                  r_wr_err;

  // Extend by one bit so NUM_ALARMS=16 still compares correctly.
  assign w_idx_ok = ({1'b0, wr_idx} < 5'(NUM_ALARMS));
  assign w_accept = wr_en && w_idx_ok && bcd_valid(wr_time);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en && !w_accept;
    end
  end

  assign wr_err = r_wr_err;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    time_bcd_t r_time;
    logic      r_arm;
    logic      w_we;

    assign w_we = w_accept && (wr_idx == C_IDX_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_time <= '0;
        r_arm  <= 1'b0;
      end else if (w_we) begin
        r_time <= wr_time;
        r_arm  <= wr_arm;
      end
    end

    assign armed_mask[i] = r_arm;
    assign w_match[i]    = r_arm && (r_time == cur_time);
  end

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        hit     = 1'b1;
        hit_idx = C_IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alarm_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_multi_ctrl
// Purpose  : Multi-slot alarm controller. Compares programmable mm:ss slots
//            against the running time on each second tick and runs the
//            IDLE / RING / SNOOZE state machine that gates the audio enable.
// Ports    : clk, rst_n        clock / async active-low reset
//            sec_tick         one-clk pulse per counted second
//            cur_time         current BCD time
//            wr_en, wr_idx, wr_time, wr_arm   slot programming
//            snooze, alarm_off                debounced button pulses
//            ringing, snoozing                registered state flags
//            ring_idx         slot that started the current event
//            armed_mask       per-slot arm bits
//            missed           sticky timeout flag, cleared by alarm_off
//            wr_err           one-cycle pulse on a rejected write
// Revision : 1.0  initial release
// ============================================================================
module alarm_multi_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sec_tick,
  input  logic [13:0]           cur_time,
  input  logic                  wr_en,
  input  logic [3:0]            wr_idx,
  input  logic [13:0]           wr_time,
  input  logic                  wr_arm,
  input  logic                  snooze,
  input  logic                  alarm_off,
  output logic                  ringing,
  output logic [3:0]            ring_idx,
  output logic                  snoozing,
  output logic [NUM_ALARMS-1:0] armed_mask,
  output logic                  missed,
  output logic                  wr_err
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_RING   = 2'(RING);
  localparam logic [1:0] S_SNOOZE = 2'(SNOOZE);

  localparam int C_RW = $clog2(RING_SECS + 1);
  localparam int C_LW = $clog2(SNOOZE_SECS + 1);
  // MAX_SNOOZE=0 would give a zero-width counter; keep at least one bit.
  localparam int C_SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [C_RW-1:0] C_RING_LAST = C_RW'(RING_SECS - 1);
  localparam logic [C_RW-1:0] C_RING_MAX  = C_RW'(RING_SECS);
  localparam logic [C_LW-1:0] C_SIL_LAST  = C_LW'(SNOOZE_SECS - 1);
  localparam logic [C_LW-1:0] C_SIL_MAX   = C_LW'(SNOOZE_SECS);
  localparam logic [C_SW-1:0] C_SNZ_MAX   = C_SW'(MAX_SNOOZE);

  logic            w_hit;
  logic [3:0]      w_hit_idx;

  logic [1:0]      r_state,    w_state_nxt;
  logic [3:0]      r_ring_idx, w_ring_idx_nxt;
  logic [C_RW-1:0] r_ring_cnt, w_ring_cnt_nxt;
  logic [C_LW-1:0] r_sil_cnt,  w_sil_cnt_nxt;
  logic [C_SW-1:0] r_snz_cnt,  w_snz_cnt_nxt;
  logic            r_missed,   w_missed_nxt;
  logic            r_ringing;
  logic            r_snoozing;

  alarm_slot_bank #(
    .NUM_ALARMS (NUM_ALARMS)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_time    (time_bcd_t'(wr_time)),
    .wr_arm     (wr_arm),
    .cur_time   (time_bcd_t'(cur_time)),
    .hit        (w_hit),
    .hit_idx    (w_hit_idx),
    .armed_mask (armed_mask),
    .wr_err     (wr_err)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_idx_nxt = r_ring_idx;
    w_ring_cnt_nxt = r_ring_cnt;
    w_sil_cnt_nxt  = r_sil_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_missed_nxt   = r_missed;

    // The sticky flag is acknowledged by alarm_off regardless of state.
    if (alarm_off) begin
      w_missed_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (sec_tick && w_hit) begin
          w_state_nxt    = S_RING;
          w_ring_idx_nxt = w_hit_idx;
          w_ring_cnt_nxt = '0;
          w_snz_cnt_nxt  = '0;
          w_sil_cnt_nxt  = '0;
        end
      end

      S_RING: begin
        if (alarm_off) begin
          w_state_nxt = S_IDLE;
        end else if (snooze) begin
          if (r_snz_cnt < C_SNZ_MAX) begin
            w_state_nxt   = S_SNOOZE;
            w_snz_cnt_nxt = r_snz_cnt + 1'b1;
            w_sil_cnt_nxt = '0;
          end else begin
            // Snooze budget exhausted: behaves as off.
            w_state_nxt = S_IDLE;
          end
        end else if (sec_tick) begin
          if (r_ring_cnt >= C_RING_LAST) begin
            w_state_nxt    = S_IDLE;
            w_ring_cnt_nxt = C_RING_MAX;
            w_missed_nxt   = 1'b1;
          end else begin
            w_ring_cnt_nxt = r_ring_cnt + 1'b1;
          end
        end
      end

      S_SNOOZE: begin
        if (alarm_off) begin
          w_state_nxt = S_IDLE;
        end else if (sec_tick) begin
          if (r_sil_cnt >= C_SIL_LAST) begin
            w_state_nxt    = S_RING;
            w_sil_cnt_nxt  = C_SIL_MAX;
            w_ring_cnt_nxt = '0;
          end else begin
            w_sil_cnt_nxt = r_sil_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ring_idx <= '0;
      r_ring_cnt <= '0;
      r_sil_cnt  <= '0;
      r_snz_cnt  <= '0;
      r_missed   <= 1'b0;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_idx <= w_ring_idx_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_sil_cnt  <= w_sil_cnt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_missed   <= w_missed_nxt;
      r_ringing  <= (w_state_nxt == S_RING);
      r_snoozing <= (w_state_nxt == S_SNOOZE);
    end
  end

  assign ringing  = r_ringing;
  assign snoozing = r_snoozing;
  assign ring_idx = r_ring_idx;
  assign missed   = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_alarm_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_multi_ctrl
// Purpose  : Directed self-checking bench for alarm_multi_ctrl with a
//            scoreboard of expected output snapshots.
// Revision : 1.0  initial release
// ============================================================================
module tb_alarm_multi_ctrl;

  localparam int NA = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sec_tick;
  logic [13:0]   cur_time;
  logic          wr_en;
  logic [3:0]    wr_idx;
  logic [13:0]   wr_time;
  logic          wr_arm;
  logic          snooze;
  logic          alarm_off;
  logic          ringing;
  logic [3:0]    ring_idx;
  logic          snoozing;
  logic [NA-1:0] armed_mask;
  logic          missed;
  logic          wr_err;

  // {ringing, snoozing, ring_idx, missed, wr_err, armed_mask}
  typedef logic [7+NA:0] snap_t;

  snap_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  alarm_multi_ctrl #(
    .NUM_ALARMS  (NA),
    .RING_SECS   (30),
    .SNOOZE_SECS (5),
    .MAX_SNOOZE  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sec_tick   (sec_tick),
    .cur_time   (cur_time),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_time    (wr_time),
    .wr_arm     (wr_arm),
    .snooze     (snooze),
    .alarm_off  (alarm_off),
    .ringing    (ringing),
    .ring_idx   (ring_idx),
    .snoozing   (snoozing),
    .armed_mask (armed_mask),
    .missed     (missed),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input int mt, input int mo, input int st, input int so);
    return {3'(mt), 4'(mo), 3'(st), 4'(so)};
  endfunction

  task automatic push_exp(input logic r, input logic s, input logic [3:0] idx,
                          input logic m, input logic e, input logic [NA-1:0] mask);
    exp_q.push_back({r, s, idx, m, e, mask});
  endtask

  task automatic check(input string tag);
    snap_t obs;
    snap_t exp;
    obs = {ringing, snoozing, ring_idx, missed, wr_err, armed_mask};
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      n_vec++;
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed {r,s,idx,m,e,mask}=%b_%b_%h_%b_%b_%b required %b_%b_%h_%b_%b_%b",
               tag, obs[7+NA], obs[6+NA], obs[5+NA:2+NA], obs[1+NA], obs[NA], obs[NA-1:0],
               exp[7+NA], exp[6+NA], exp[5+NA:2+NA], exp[1+NA], exp[NA], exp[NA-1:0]);
      end
    end
  endtask

  // One clock edge; pulses are cleared after it so each lasts one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    wr_en     = 1'b0;
    sec_tick  = 1'b0;
    snooze    = 1'b0;
    alarm_off = 1'b0;
  endtask

  task automatic do_step(input string tag, input logic r, input logic s, input logic [3:0] idx,
                         input logic m, input logic e, input logic [NA-1:0] mask);
    push_exp(r, s, idx, m, e, mask);
    step();
    check(tag);
  endtask

  task automatic set_wr(input int idx, input logic [13:0] t, input logic arm);
    wr_en   = 1'b1;
    wr_idx  = 4'(idx);
    wr_time = t;
    wr_arm  = arm;
  endtask

  initial begin
    rst_n = 1'b0; sec_tick = 1'b0; cur_time = '0; wr_en = 1'b0; wr_idx = '0;
    wr_time = '0; wr_arm = 1'b0; snooze = 1'b0; alarm_off = 1'b0;

    #3;
    push_exp(0, 0, 4'd0, 0, 0, 4'b0000);
    check("reset_init");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Slot0 = 01:30 armed, then match it to get into RING.
    set_wr(0, mk(0,1,3,0), 1'b1);
    do_step("wr_slot0", 0, 0, 4'd0, 0, 0, 4'b0001);
    cur_time = mk(0,1,3,0); sec_tick = 1'b1;
    do_step("ring_slot0", 1, 0, 4'd0, 0, 0, 4'b0001);

    // Async reset mid-RING takes effect before any clock edge.
    #2; rst_n = 1'b0; #1;
    push_exp(0, 0, 4'd0, 0, 0, 4'b0000);
    check("async_reset");
    @(negedge clk); rst_n = 1'b1;

    // Slot2 and slot1 both at 01:30; lowest index wins.
    set_wr(2, mk(0,1,3,0), 1'b1);
    do_step("wr_slot2", 0, 0, 4'd0, 0, 0, 4'b0100);
    set_wr(1, mk(0,1,3,0), 1'b1);
    do_step("wr_slot1", 0, 0, 4'd0, 0, 0, 4'b0110);
    cur_time = mk(0,1,3,0); sec_tick = 1'b1;
    do_step("ring_prio", 1, 0, 4'd1, 0, 0, 4'b0110);

    // Timeout after 30 ticks with no input.
    cur_time = mk(0,0,0,0);
    for (int i = 0; i < 28; i++) begin
      sec_tick = 1'b1; step();
    end
    sec_tick = 1'b1;
    do_step("tick29_still_ring", 1, 0, 4'd1, 0, 0, 4'b0110);
    sec_tick = 1'b1;
    do_step("tick30_timeout", 0, 0, 4'd1, 1, 0, 4'b0110);
    alarm_off = 1'b1;
    do_step("off_clears_missed", 0, 0, 4'd1, 0, 0, 4'b0110);

    // Snooze cycle: three snoozes of 5 ticks, fourth acts as off.
    cur_time = mk(0,1,3,0); sec_tick = 1'b1;
    do_step("ring_again", 1, 0, 4'd1, 0, 0, 4'b0110);
    cur_time = mk(0,0,0,0);
    set_wr(3, mk(0,2,0,0), 1'b1);
    do_step("wr_slot3_in_ring", 1, 0, 4'd1, 0, 0, 4'b1110);
    for (int k = 0; k < 3; k++) begin
      snooze = 1'b1;
      do_step("snooze_enter", 0, 1, 4'd1, 0, 0, 4'b1110);
      // Slot3 matches during the first silence period and must be dropped.
      if (k == 0) cur_time = mk(0,2,0,0);
      for (int t = 0; t < 3; t++) begin
        sec_tick = 1'b1; step();
        cur_time = mk(0,0,0,0);
      end
      snooze = 1'b1; sec_tick = 1'b1;   // snooze ignored while silent
      do_step("snooze_tick4", 0, 1, 4'd1, 0, 0, 4'b1110);
      sec_tick = 1'b1;
      do_step("snooze_rering", 1, 0, 4'd1, 0, 0, 4'b1110);
    end
    snooze = 1'b1;
    do_step("snooze4_as_off", 0, 0, 4'd1, 0, 0, 4'b1110);

    // Rejected writes: bad BCD and out-of-range index.
    set_wr(0, mk(6,0,0,0), 1'b1);
    do_step("wr_err_min_tens", 0, 0, 4'd1, 0, 1, 4'b1110);
    do_step("wr_err_one_cycle", 0, 0, 4'd1, 0, 0, 4'b1110);
    set_wr(NA, mk(0,1,0,0), 1'b1);
    do_step("wr_err_idx", 0, 0, 4'd1, 0, 1, 4'b1110);
    set_wr(0, mk(0,1,0,10), 1'b1);
    do_step("wr_err_sec_ones", 0, 0, 4'd1, 0, 1, 4'b1110);

    // Disarming the ringing slot does not stop the event; snooze+off -> IDLE.
    cur_time = mk(0,1,3,0); sec_tick = 1'b1;
    do_step("ring_slot1", 1, 0, 4'd1, 0, 0, 4'b1110);
    cur_time = mk(0,0,0,0);
    set_wr(1, mk(0,1,3,0), 1'b0);
    do_step("disarm_mid_ring", 1, 0, 4'd1, 0, 0, 4'b1100);
    snooze = 1'b1; alarm_off = 1'b1;
    do_step("snooze_and_off", 0, 0, 4'd1, 0, 0, 4'b1100);

    // Slot1 now disarmed: 01:30 matches slot2; 02:00 matches slot3.
    cur_time = mk(0,1,3,0); sec_tick = 1'b1;
    do_step("ring_slot2", 1, 0, 4'd2, 0, 0, 4'b1100);
    alarm_off = 1'b1;
    do_step("off_slot2", 0, 0, 4'd2, 0, 0, 4'b1100);
    cur_time = mk(0,2,0,0); sec_tick = 1'b1;
    do_step("ring_slot3", 1, 0, 4'd3, 0, 0, 4'b1100);
    alarm_off = 1'b1; cur_time = mk(0,0,0,0);
    do_step("off_slot3", 0, 0, 4'd3, 0, 0, 4'b1100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
